cell_test_sequencer: RTL

- Sequencer that drives the inputs of one combinational library cell (default: AOI211) through every input vector and checks the cell's output against a golden truth table.
- Used on the characterization/bring-up board and in simulation to sign off transistor-level cells.
- Applies a vector, waits a settle window, samples Y, compares it, and advances to the next vector.
- Reports pass/fail, the error count and the first failing vector.

---
 rtl/cell_test_pkg.sv | 14 +
 rtl/cell_test_sequencer_if.sv | 26 ++
 rtl/cell_test_settle_timer.sv | 36 +++
 rtl/cell_test_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cell_test_pkg.sv
// Shared types and golden truth tables for the library-cell test sequencer.
package cell_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_FINISH
    } state_e;

    // Bit i is the expected Y for input vector i; AOI211 vector is {A,B,C1,C2}.
    localparam logic [15:0] AOI211_TRUTH = 16'h0007;

endpackage

// File: rtl/cell_test_sequencer_if.sv
// Control, status and cell-facing signals of the test sequencer.
interface cell_test_sequencer_if #(
    parameter int N_IN = 4,
    parameter int ERRW = N_IN + 1
);
    logic            start;
    logic            loop;
    logic            dut_y;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;
    logic            pass;
    logic [ERRW-1:0] err_count;
    logic            fail_valid;
    logic [N_IN-1:0] first_fail_vec;

    modport master (
        input  start, loop, dut_y,
        output stim, busy, done, pass, err_count, fail_valid, first_fail_vec
    );

    modport slave (
        output start, loop, dut_y,
        input  stim, busy, done, pass, err_count, fail_valid, first_fail_vec
    );
endinterface

// File: rtl/cell_test_settle_timer.sv
// Down-counter that times how long each vector is held before Y is sampled.
module cell_test_settle_timer #(
    parameter int SETTLE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero
);
    localparam int            CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/cell_test_sequencer.sv
// Walks a combinational cell through every input vector and checks Y against a truth table.
module cell_test_sequencer
    import cell_test_pkg::*;
#(
    parameter int                     N_IN   = 4,
    parameter int                     SETTLE = 3,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = AOI211_TRUTH,
    parameter int                     ERRW   = N_IN + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    cell_test_sequencer_if.master bus
);
    localparam int            VW       = N_IN + 1;
    localparam logic [VW-1:0] LAST_VEC = VW'((1 << N_IN) - 1);

    state_e          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [ERRW-1:0] err_count_q, err_count_d;
    logic            fail_valid_q, fail_valid_d;
    logic [N_IN-1:0] first_fail_vec_q, first_fail_vec_d;

    logic timer_load;
    logic timer_dec;
    logic timer_zero;
    logic mismatch;

    cell_test_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .zero (timer_zero)
    );

    assign mismatch = (bus.dut_y != TRUTH[vec_q[N_IN-1:0]]);

    always_comb begin
        state_d          = state_q;
        vec_d            = vec_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        pass_d           = pass_q;
        err_count_d      = err_count_q;
        fail_valid_d     = fail_valid_q;
        first_fail_vec_d = first_fail_vec_q;
        timer_load       = 1'b0;
        timer_dec        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    vec_d        = '0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    pass_d       = 1'b0;
                    busy_d       = 1'b1;
                    timer_load   = 1'b1;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    timer_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + ERRW'(1);
                    end
                    if (!fail_valid_q) begin
                        first_fail_vec_d = vec_q[N_IN-1:0];
                        fail_valid_d     = 1'b1;
                    end
                end
                if (vec_q < LAST_VEC) begin
                    vec_d      = vec_q + VW'(1);
                    timer_load = 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    // Registering done/pass here lines them up with the FINISH cycle.
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0) && !fail_valid_d;
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                vec_d = '0;
                if (bus.loop) begin
                    timer_load = 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            vec_q            <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            fail_valid_q     <= 1'b0;
            first_fail_vec_q <= '0;
        end else begin
            state_q          <= state_d;
            vec_q            <= vec_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_count_q      <= err_count_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_vec_q <= first_fail_vec_d;
        end
    end

    assign bus.stim           = vec_q[N_IN-1:0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_count_q;
    assign bus.fail_valid     = fail_valid_q;
    assign bus.first_fail_vec = first_fail_vec_q;

endmodule
